chip8_framebuffer_engine: RTL and testbench

- Parametrised successor to the Chip8 frame store: a WIDTH x HEIGHT 1-bit pixel memory with a sprite-row XOR draw engine, collision detection, multi-cycle clear, and an independent display read port.
- Sits between the Chip8 CPU (DRW/CLS instructions) and the VGA emulator. The CPU issues commands over a valid/ready handshake; the VGA side reads pixels every cycle.

---
 rtl/chip8_fb_pkg.sv | 15 +
 rtl/chip8_sprite_mask.sv | 28 ++
 rtl/chip8_framebuffer_engine.sv | 138 +++++++++++++
 tb/tb_chip8_framebuffer_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_fb_pkg.sv
// Shared types and default geometry for the Chip8 frame store and its sprite mask helper.
package chip8_fb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        DRAW_RD = 2'd2,
        DRAW_WR = 2'd3
    } fb_state_t;

    localparam int CHIP8_FB_W     = 64;
    localparam int CHIP8_FB_H     = 32;
    localparam int CHIP8_SPRITE_W = 8;

endpackage

// File: rtl/chip8_sprite_mask.sv
// Places a sprite row at column x inside a WIDTH-bit row (bit WIDTH-1 = column 0),
// wrapping or clipping the pixels that fall past the right edge.
module chip8_sprite_mask
    import chip8_fb_pkg::*;
#(
    parameter int WIDTH    = CHIP8_FB_W,
    parameter int SPRITE_W = CHIP8_SPRITE_W,
    parameter int WRAP     = 1,
    parameter int XW       = $clog2(WIDTH)
) (
    input  logic [XW-1:0]       x,
    input  logic [SPRITE_W-1:0] data,
    output logic [WIDTH-1:0]    mask
);

    logic [2*WIDTH-1:0] wide;

    // Upper half holds columns 0..WIDTH-1; lower half holds the overflow columns,
    // already at the bit position their wrapped column would occupy.
    always_comb begin
        wide = {data, {(2*WIDTH-SPRITE_W){1'b0}}} >> x;
        mask = wide[2*WIDTH-1:WIDTH];
        if (WRAP != 0) begin
            mask = mask | wide[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/chip8_framebuffer_engine.sv
// Chip8 1-bit frame store: sprite-row XOR draw with collision, row-per-cycle clear,
// and an always-on registered display read port.
module chip8_framebuffer_engine
    import chip8_fb_pkg::*;
#(
    parameter int WIDTH    = CHIP8_FB_W,
    parameter int HEIGHT   = CHIP8_FB_H,
    parameter int SPRITE_W = CHIP8_SPRITE_W,
    parameter int WRAP     = 1,
    parameter int XW       = $clog2(WIDTH),
    parameter int YW       = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cls_valid,
    input  logic                draw_valid,
    input  logic [7:0]          draw_x,
    input  logic [7:0]          draw_y,
    input  logic [SPRITE_W-1:0] draw_data,
    input  logic                draw_first,
    output logic                cmd_ready,
    output logic                done,
    output logic                collision,
    output logic                busy,
    input  logic [XW-1:0]       rd_x,
    input  logic [YW-1:0]       rd_y,
    output logic                rd_pixel,
    output logic [1:0]          dbg_state
);

    // Handshake: a command is taken on a clk edge where its valid and cmd_ready are
    // both high; cls has priority, a losing draw must stay valid until it is taken.
    fb_state_t            state, state_nx;
    logic [WIDTH-1:0]     mem [HEIGHT];
    logic [YW-1:0]        clr_row;
    logic [XW-1:0]        x_q;
    logic [7:0]           y_q;
    logic [SPRITE_W-1:0]  data_q;
    logic [WIDTH-1:0]     hold_q;
    logic [WIDTH-1:0]     mask_q;
    logic [WIDTH-1:0]     mask_c;
    logic                 row_ok;
    logic                 cls_acc;
    logic                 draw_acc;
    logic                 done_c;

    chip8_sprite_mask #(
        .WIDTH    (WIDTH),
        .SPRITE_W (SPRITE_W),
        .WRAP     (WRAP),
        .XW       (XW)
    ) u_mask (
        .x    (x_q),
        .data (data_q),
        .mask (mask_c)
    );

    // With clipping, rows at or beyond HEIGHT are simply not drawn.
    assign row_ok    = (WRAP != 0) || ((y_q >> YW) == 8'd0);
    assign cmd_ready = reset_n && (state == IDLE);
    assign busy      = reset_n && (state != IDLE);
    assign done      = reset_n && done_c;
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        done_c   = 1'b0;
        cls_acc  = 1'b0;
        draw_acc = 1'b0;
        case (state)
            IDLE: begin
                if (cls_valid) begin
                    cls_acc  = 1'b1;
                    state_nx = CLEAR;
                end else if (draw_valid) begin
                    draw_acc = 1'b1;
                    state_nx = DRAW_RD;
                end
            end
            CLEAR: begin
                if (clr_row == YW'(HEIGHT - 1)) begin
                    done_c   = 1'b1;
                    state_nx = IDLE;
                end
            end
            DRAW_RD: state_nx = DRAW_WR;
            DRAW_WR: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            clr_row   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            data_q    <= '0;
            hold_q    <= '0;
            mask_q    <= '0;
            collision <= 1'b0;
            rd_pixel  <= 1'b0;
            for (int r = 0; r < HEIGHT; r++) begin
                mem[r] <= '0;
            end
        end else begin
            state    <= state_nx;
            rd_pixel <= mem[rd_y][XW'(WIDTH - 1) - rd_x];
            if (cls_acc) begin
                clr_row <= '0;
            end
            if (state == CLEAR) begin
                mem[clr_row] <= '0;
                clr_row      <= clr_row + 1'b1;
            end
            if (draw_acc) begin
                x_q    <= draw_x[XW-1:0];
                y_q    <= draw_y;
                data_q <= draw_data;
                if (draw_first) begin
                    collision <= 1'b0;
                end
            end
            if (state == DRAW_RD) begin
                hold_q <= mem[y_q[YW-1:0]];
                mask_q <= mask_c;
            end
            if (state == DRAW_WR && row_ok) begin
                mem[y_q[YW-1:0]] <= hold_q ^ mask_q;
                collision        <= collision | (|(hold_q & mask_q));
            end
        end
    end

endmodule

// File: tb/tb_chip8_framebuffer_engine.sv
// Drives a wrapping and a clipping frame store with identical commands and compares
// every row and collision flag against a per-pixel model of the drawing rules.
module tb_chip8_framebuffer_engine;
    import chip8_fb_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cls_valid;
    logic       draw_valid;
    logic [7:0] draw_x;
    logic [7:0] draw_y;
    logic [7:0] draw_data;
    logic       draw_first;
    logic [5:0] rd_x;
    logic [4:0] rd_y;

    logic       rdy_w1, done_w1, coll_w1, busy_w1, pix_w1;
    logic       rdy_w0, done_w0, coll_w0, busy_w0, pix_w0;
    logic [1:0] dbg_w1, dbg_w0;

    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] exp_q[$];

    // model: [instance: 1 = wrap, 0 = clip][row][column]
    bit m_px [2][32][64];
    bit m_col [2];

    chip8_framebuffer_engine #(.WRAP(1)) u_w1 (
        .clk(clk), .reset_n(reset_n), .cls_valid(cls_valid), .draw_valid(draw_valid),
        .draw_x(draw_x), .draw_y(draw_y), .draw_data(draw_data), .draw_first(draw_first),
        .cmd_ready(rdy_w1), .done(done_w1), .collision(coll_w1), .busy(busy_w1),
        .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(pix_w1), .dbg_state(dbg_w1)
    );

    chip8_framebuffer_engine #(.WRAP(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .cls_valid(cls_valid), .draw_valid(draw_valid),
        .draw_x(draw_x), .draw_y(draw_y), .draw_data(draw_data), .draw_first(draw_first),
        .cmd_ready(rdy_w0), .done(done_w0), .collision(coll_w0), .busy(busy_w0),
        .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(pix_w0), .dbg_state(dbg_w0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            m_col[w] = 1'b0;
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 64; x++)
                    m_px[w][y][x] = 1'b0;
        end
    endfunction

    function automatic void model_clear();
        for (int w = 0; w < 2; w++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 64; x++)
                    m_px[w][y][x] = 1'b0;
    endfunction

    function automatic void model_draw(input int w, input int x, input int y,
                                       input logic [7:0] d, input bit f);
        int c;
        int yr;
        if (f) m_col[w] = 1'b0;
        if (w == 0 && y >= 32) return;
        yr = y % 32;
        for (int i = 0; i < 8; i++) begin
            if (d[7-i]) begin
                c = (x % 64) + i;
                if (c >= 64) begin
                    if (w == 0) continue;
                    c = c - 64;
                end
                if (m_px[w][yr][c]) m_col[w] = 1'b1;
                m_px[w][yr][c] = ~m_px[w][yr][c];
            end
        end
    endfunction

    function automatic logic [63:0] model_row(input int w, input int y);
        logic [63:0] r;
        for (int x = 0; x < 64; x++) r[63-x] = m_px[w][y][x];
        return r;
    endfunction

    // Called at a negedge; one pixel per cycle through the read port.
    task automatic scan(input string tag);
        logic [63:0] g1, g0;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 64; x++) begin
                rd_x = 6'(x);
                rd_y = 5'(y);
                @(negedge clk);
                g1[63-x] = pix_w1;
                g0[63-x] = pix_w0;
            end
            exp_q.push_back(model_row(1, y));
            exp_q.push_back(model_row(0, y));
            chk($sformatf("%s_w1_row%0d", tag, y), g1, exp_q.pop_front());
            chk($sformatf("%s_w0_row%0d", tag, y), g0, exp_q.pop_front());
        end
    endtask

    // Entered at the negedge just before the accepting edge.
    task automatic finish_draw(input int x, input int y, input logic [7:0] d, input bit f);
        int lat;
        @(negedge clk);
        draw_valid = 1'b0;
        lat = 1;
        while (!done_w1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("draw_latency", 64'(lat), 64'd2);
        chk("draw_done_w0", done_w0, 1'b1);
        model_draw(1, x, y, d, f);
        model_draw(0, x, y, d, f);
        @(negedge clk);
        chk("done_single_pulse", {done_w1, done_w0}, 2'b00);
        chk("collision_w1", coll_w1, m_col[1]);
        chk("collision_w0", coll_w0, m_col[0]);
    endtask

    task automatic do_draw(input int x, input int y, input logic [7:0] d, input bit f);
        int n;
        draw_x     = 8'(x);
        draw_y     = 8'(y);
        draw_data  = d;
        draw_first = f;
        draw_valid = 1'b1;
        n = 0;
        while (!rdy_w1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("draw_ready", rdy_w1, 1'b1);
        finish_draw(x, y, d, f);
    endtask

    task automatic do_cls();
        int n;
        cls_valid = 1'b1;
        @(negedge clk);
        cls_valid = 1'b0;
        n = 0;
        while (!done_w1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cls_done_seen", done_w1, 1'b1);
        model_clear();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, {dbg_w1, dbg_w0}, {IDLE, IDLE});
        chk({tag, "_outs_w1"}, {rdy_w1, busy_w1, done_w1, coll_w1}, 4'b0000);
        chk({tag, "_outs_w0"}, {rdy_w0, busy_w0, done_w0, coll_w0}, 4'b0000);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        reset_n    = 1'b0;
        cls_valid  = 1'b0;
        draw_valid = 1'b0;
        draw_x     = '0;
        draw_y     = '0;
        draw_data  = '0;
        draw_first = 1'b0;
        rd_x       = '0;
        rd_y       = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_pixel", {pix_w1, pix_w0}, 2'b00);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {rdy_w1, rdy_w0}, 2'b11);

        do_draw(0, 0, 8'hF0, 1'b1);
        scan("first_draw");
        do_draw(0, 0, 8'hF0, 1'b1);
        do_draw(10, 5, 8'h81, 1'b0);
        scan("redraw");

        do_draw(62, 31, 8'hFF, 1'b1);
        do_draw(0, 33, 8'h3C, 1'b0);
        do_draw(62, 40, 8'hAA, 1'b1);
        do_draw(3, 12, 8'h5A, 1'b0);
        scan("edges");

        // cls and draw together: clear is taken, the held draw follows it
        draw_x = 8'd5; draw_y = 8'd7; draw_data = 8'h99; draw_first = 1'b1;
        draw_valid = 1'b1;
        cls_valid  = 1'b1;
        chk("ready_before_cls", rdy_w1, 1'b1);
        @(negedge clk);
        cls_valid = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        while (busy_w1 && busy_cnt < 100) begin
            busy_cnt++;
            if (done_w1) done_at = busy_cnt;
            @(negedge clk);
        end
        chk("cls_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("cls_done_cycle", 64'(done_at), 64'd32);
        chk("ready_after_cls", {rdy_w1, rdy_w0}, 2'b11);
        chk("cls_keeps_collision", {coll_w1, coll_w0}, {m_col[1], m_col[0]});
        model_clear();
        finish_draw(5, 7, 8'h99, 1'b1);
        scan("after_cls");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 15) == 0) do_cls();
            else do_draw($urandom_range(0, 255), $urandom_range(0, 63),
                         8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        scan("random");

        // reset in the middle of a clear
        cls_valid = 1'b1;
        @(negedge clk);
        cls_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_clear_state", dbg_w1, CLEAR);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_clear");
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_clear_no_done", {done_w1, done_w0, rdy_w1, rdy_w0}, 4'b0011);
        for (int i = 0; i < 12; i++)
            do_draw($urandom_range(0, 63), $urandom_range(0, 31),
                    8'($urandom_range(1, 255)), 1'b0);
        scan("rst_clear");

        // reset while the draw is reading its row
        draw_x = 8'd20; draw_y = 8'd3; draw_data = 8'hFF; draw_first = 1'b0;
        draw_valid = 1'b1;
        @(negedge clk);
        draw_valid = 1'b0;
        chk("mid_draw_state", dbg_w1, DRAW_RD);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_draw");
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_draw_no_done", {done_w1, done_w0, busy_w1, busy_w0}, 4'b0000);
        @(negedge clk);
        chk("rst_draw_no_done2", {done_w1, done_w0}, 2'b00);
        scan("rst_draw");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
